// File: rtl/gate_vector_sequencer.sv
// Steps a 2-input gate through vectors 00..11 with a programmable dwell and captures its truth table.
// Optional GATE_SELFCHECK_EN adds an expected-table input and a registered mismatch flag.
module gate_vector_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  input  logic               y,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic [3:0]         truth,
`ifdef GATE_SELFCHECK_EN
  output logic               valid,
  input  logic [3:0]         expected,
  output logic               mismatch
`else
  output logic               valid
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [DWELL_W-1:0] CntOne = DWELL_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         truth_q, truth_d;
  logic               valid_q, valid_d;
  logic [DWELL_W-1:0] cnt_last;
  logic [1:0]         idx_inc;
`ifdef GATE_SELFCHECK_EN
  logic               mismatch_q, mismatch_d;
`endif

  // A latched dwell of zero behaves as one cycle per vector.
  assign cnt_last = (dwell_q == '0) ? '0 : (dwell_q - CntOne);
  assign idx_inc  = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    truth_d    = truth_q;
    valid_d    = valid_q;
`ifdef GATE_SELFCHECK_EN
    mismatch_d = mismatch_q;
`endif

    unique case (state_q)
      StIdle: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d = StRun;
          dwell_d = dwell;
          valid_d = 1'b0;
          truth_d = 4'b0000;
          idx_d   = 2'd0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      StRun: begin
        if (cnt_q == cnt_last) begin
          truth_d[idx_q] = y;
          cnt_d          = '0;
          if (idx_q == 2'd3) begin
            state_d = StDone;
            done_d  = 1'b1;
            valid_d = 1'b1;
`ifdef GATE_SELFCHECK_EN
            // Compare against the table including the sample taken this cycle.
            mismatch_d = ({y, truth_q[2:0]} != expected);
`endif
          end else begin
            idx_d = idx_inc;
            a_d   = idx_inc[1];
            b_d   = idx_inc[0];
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StDone: begin
        if (loop) begin
          // Restart without clearing truth; each bit is overwritten as it is recaptured.
          state_d = StRun;
          dwell_d = dwell;
          idx_d   = 2'd0;
          cnt_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      dwell_q    <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      truth_q    <= 4'b0000;
      valid_q    <= 1'b0;
`ifdef GATE_SELFCHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      truth_q    <= truth_d;
      valid_q    <= valid_d;
`ifdef GATE_SELFCHECK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign truth = truth_q;
  assign valid = valid_q;
`ifdef GATE_SELFCHECK_EN
  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: a behavioural gate drives y, a scoreboard holds
// expected truth tables and done latencies per sweep.
module tb_gate_vector_sequencer;

  localparam int ModeAnd = 0;
  localparam int ModeOr  = 1;
  localparam int ModeXor = 2;

  logic       clk = 1'b0;
  logic       rst, start, loop, y;
  logic [7:0] dwell;
  logic       a, b, busy, done, valid;
  logic [3:0] truth;
`ifdef GATE_SELFCHECK_EN
  logic [3:0] expected;
  logic       mismatch;
`endif

  int mode;
  int total = 0;
  int bad   = 0;
  logic [3:0] exp_truth_q[$];
  int         exp_lat_q[$];

  always #5 clk = ~clk;

  gate_vector_sequencer #(.DWELL_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dwell    (dwell),
    .loop     (loop),
    .y        (y),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .truth    (truth),
`ifdef GATE_SELFCHECK_EN
    .valid    (valid),
    .expected (expected),
    .mismatch (mismatch)
`else
    .valid    (valid)
`endif
  );

  function automatic logic gate_f(input int m, input logic ga, input logic gb);
    case (m)
      ModeAnd: return ga & gb;
      ModeOr:  return ga | gb;
      default: return ga ^ gb;
    endcase
  endfunction

  function automatic logic [3:0] model_truth(input int m);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v    = 2'(i);
      t[i] = gate_f(m, v[1], v[0]);
    end
    return t;
  endfunction

  always_comb y = gate_f(mode, a, b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_dwell(input logic [7:0] dw);
    return (dw == 8'd0) ? 1 : int'(dw);
  endfunction

  task automatic push_sweep(input int m, input logic [7:0] dw);
    exp_truth_q.push_back(model_truth(m));
    exp_lat_q.push_back(4 * eff_dwell(dw));
  endtask

  // Called #1 after the edge that launched the sweep (start edge or previous DONE edge).
  task automatic observe(input logic [7:0] dw, input bit poke, input bit scramble,
                         input logic [3:0] t0, input logic v0);
    int d;
    int n;
    logic [3:0] et;
    int el;
    d = eff_dwell(dw);
    n = 0;
    check("truth_at_launch", truth, t0);
    check("valid_at_launch", valid, v0);
    while (done !== 1'b1 && n < 4 * d + 8) begin
      if (n < 4 * d) begin
        check("ab_vector", {a, b}, n / d);
        check("busy_run", busy, 1);
      end
      start = (poke && n == 2);
      if (scramble && n == 0) dwell = ~dw;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    dwell = dw;
    et = exp_truth_q.pop_front();
    el = exp_lat_q.pop_front();
    check("done_latency", n, el);
    check("truth_done", truth, et);
    check("valid_done", valid, 1);
    check("busy_done", busy, 1);
    check("ab_done", {a, b}, 2'b11);
  endtask

  task automatic launch(input int m, input logic [7:0] dw);
    mode  = m;
    dwell = dw;
    push_sweep(m, dw);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_idle(input logic [3:0] t, input string tag);
    @(posedge clk);
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ab"}, {a, b}, 0);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_truth"}, truth, t);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    loop  = 1'b0;
    dwell = 8'd0;
    mode  = ModeOr;
`ifdef GATE_SELFCHECK_EN
    expected = 4'b0000;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {a, b, busy, done, valid, truth}, 0);
`ifdef GATE_SELFCHECK_EN
    check("reset_mismatch", mismatch, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", {a, b, busy, done, valid}, 0);

    // OR, dwell=3, stray start mid-sweep and dwell changed after latching.
    launch(ModeOr, 8'd3);
    observe(8'd3, 1'b1, 1'b1, 4'b0000, 1'b0);
    check_idle(4'b1110, "or_idle");
    repeat (3) @(posedge clk);
    #1;
    check("or_no_restart", {busy, done}, 0);

    // AND, dwell=0 behaves as one cycle per vector.
    launch(ModeAnd, 8'd0);
    observe(8'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    check_idle(4'b1000, "and_idle");

    // XOR, dwell=2 with loop: done every 9 cycles, truth kept across sweeps.
    loop = 1'b1;
    launch(ModeXor, 8'd2);
    observe(8'd2, 1'b0, 1'b0, 4'b0000, 1'b0);
    push_sweep(ModeXor, 8'd2);
    @(posedge clk);
    #1;
    observe(8'd2, 1'b1, 1'b0, 4'b0110, 1'b1);
    push_sweep(ModeXor, 8'd2);
    @(posedge clk);
    #1;
    loop = 1'b0;
    observe(8'd2, 1'b0, 1'b0, 4'b0110, 1'b1);
    check_idle(4'b0110, "xor_idle");

    // Reset during vector 10 of an OR sweep.
    mode  = ModeOr;
    dwell = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_ab", {a, b}, 2'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_sweep", {a, b, busy, done, valid, truth}, 0);
    @(posedge clk);
    #1;
    check("rst_stays_idle", {busy, done}, 0);

    // rst wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_beats_start", {a, b, busy, done}, 0);

`ifdef GATE_SELFCHECK_EN
    expected = 4'b1110;
    launch(ModeOr, 8'd1);
    observe(8'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("mismatch_clear", mismatch, 0);
    check_idle(4'b1110, "sc_idle0");
    expected = 4'b1000;
    launch(ModeOr, 8'd1);
    observe(8'd1, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("mismatch_set", mismatch, 1);
    check_idle(4'b1110, "sc_idle1");
    expected = 4'b1110;
    launch(ModeOr, 8'd2);
    check("mismatch_held_start", mismatch, 1);
    observe(8'd2, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("mismatch_recleared", mismatch, 0);
    check_idle(4'b1110, "sc_idle2");
`endif

    // Maximum dwell: no counter wrap, done after 4*255 edges.
    launch(ModeOr, 8'd255);
    observe(8'd255, 1'b0, 1'b0, 4'b0000, 1'b0);
    check_idle(4'b1110, "max_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
